// File: rtl/adc_thresh_mon.sv
`default_nettype none
// ============================================================================
//  Module   : adc_thresh_mon
//  Purpose  : Multi-channel A2D low-threshold monitor. Each channel has a
//             runtime threshold, fixed hysteresis and a consecutive-sample
//             debounce. Outputs are registered low/sticky flags and a
//             priority-encoded alarm (lowest channel index wins).
//  Options  : define ADC_MON_STALE_EN to build per-channel stale timers
//             (stale_flg); otherwise stale_flg is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module adc_thresh_mon #(
  parameter int              NUM_CH  = 4,
  parameter int              DW      = 12,
  parameter logic [DW-1:0]   HYST    = 'h020,
  parameter int              DEB_CNT = 3,
  parameter int              CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int              TMO_CYC = 2**20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 smpl_vld,
  input  logic [CH_W-1:0]      smpl_ch,
  input  logic [DW-1:0]        smpl,
  input  logic [NUM_CH*DW-1:0] thr_lo,
  input  logic                 clr_sticky,
  output logic [NUM_CH-1:0]    low_flg,
  output logic [NUM_CH-1:0]    sticky_flg,
  output logic                 any_low,
  output logic [CH_W-1:0]      alarm_ch,
  output logic                 alarm_vld,
  output logic [NUM_CH-1:0]    stale_flg
);

  typedef enum logic [1:0] {
    NORM     = 2'd0,
    PEND_LO  = 2'd1,
    LOW      = 2'd2,
    PEND_CLR = 2'd3
  } ch_state_t;

  localparam logic [3:0]  c_DEB  = 4'(DEB_CNT);
  localparam logic [DW:0] c_FULL = {1'b0, {DW{1'b1}}};

  logic [NUM_CH-1:0] w_hit;        // sample strobe addressed to channel i
  logic [NUM_CH-1:0] w_low_nxt;    // low flag implied by next FSM state
  logic [NUM_CH-1:0] w_sticky_set;
  logic [NUM_CH-1:0] w_stale_set;
  logic [CH_W-1:0]   w_alarm_nxt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_t     r_state;
    ch_state_t     w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [DW-1:0] w_thr;
    logic [DW:0]   w_rel_sum;
    logic [DW-1:0] w_rel;
    logic          w_is_low;
    logic          w_is_rel;

    // Release level is threshold plus hysteresis, clamped to full scale so a
    // channel with a high threshold can still release on a full-scale sample.
    assign w_thr     = thr_lo[i*DW +: DW];
    assign w_rel_sum = {1'b0, w_thr} + {1'b0, HYST};
    assign w_rel     = (w_rel_sum > c_FULL) ? {DW{1'b1}} : w_rel_sum[DW-1:0];
    assign w_is_low  = (smpl < w_thr);
    assign w_is_rel  = (smpl >= w_rel);
    assign w_hit[i]  = smpl_vld && (smpl_ch == CH_W'(i));
    assign w_low_nxt[i] = (w_state_nxt == LOW) || (w_state_nxt == PEND_CLR);

    // Next-state and debounce count; only a sample for this channel moves it.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (w_hit[i]) begin
        case (r_state)
          NORM: begin
            if (w_is_low) begin
              if (c_DEB <= 4'd1) begin
                w_state_nxt = LOW;
                w_cnt_nxt   = 4'd0;
              end else begin
                w_state_nxt = PEND_LO;
                w_cnt_nxt   = 4'd1;
              end
            end
          end
          PEND_LO: begin
            if (w_is_low) begin
              if (r_cnt + 4'd1 >= c_DEB) begin
                w_state_nxt = LOW;
                w_cnt_nxt   = 4'd0;
              end else begin
                w_cnt_nxt   = r_cnt + 4'd1;
              end
            end else begin
              w_state_nxt = NORM;
              w_cnt_nxt   = 4'd0;
            end
          end
          LOW: begin
            if (w_is_rel) begin
              if (c_DEB <= 4'd1) begin
                w_state_nxt = NORM;
                w_cnt_nxt   = 4'd0;
              end else begin
                w_state_nxt = PEND_CLR;
                w_cnt_nxt   = 4'd1;
              end
            end
          end
          PEND_CLR: begin
            if (w_is_rel) begin
              if (r_cnt + 4'd1 >= c_DEB) begin
                w_state_nxt = NORM;
                w_cnt_nxt   = 4'd0;
              end else begin
                w_cnt_nxt   = r_cnt + 4'd1;
              end
            end else begin
              w_state_nxt = LOW;
              w_cnt_nxt   = 4'd0;
            end
          end
          default: begin
            w_state_nxt = NORM;
            w_cnt_nxt   = 4'd0;
          end
        endcase
      end
    end

    // Per-channel state register; reset discards any partial debounce.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= NORM;
        r_cnt   <= 4'd0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

`ifdef ADC_MON_STALE_EN
  localparam int              c_AW  = $clog2(TMO_CYC + 1);
  localparam logic [c_AW-1:0] c_TMO = c_AW'(TMO_CYC);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_age
    logic [c_AW-1:0] r_age;

    // Saturating age since the last sample for this channel.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_age <= '0;
      end else if (w_hit[i]) begin
        r_age <= '0;
      end else if (r_age < c_TMO) begin
        r_age <= r_age + 1'b1;
      end
    end

    assign stale_flg[i] = (r_age >= c_TMO);
  end

  assign w_stale_set = stale_flg;
`else
  logic unused_tmo;
  assign unused_tmo  = (TMO_CYC == 0);
  assign stale_flg   = '0;
  assign w_stale_set = '0;
`endif

  // A rising low flag (or a stale channel) sets sticky, overriding a clear.
  assign w_sticky_set = (w_low_nxt & ~low_flg) | w_stale_set;

  // Lowest-index low channel; hold the previous index when none are low.
  always_comb begin
    w_alarm_nxt = alarm_ch;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_low_nxt[k]) begin
        w_alarm_nxt = CH_W'(k);
      end
    end
  end

  // Output registers, all aligned to the next-state flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      low_flg    <= '0;
      sticky_flg <= '0;
      any_low    <= 1'b0;
      alarm_vld  <= 1'b0;
      alarm_ch   <= '0;
    end else begin
      low_flg    <= w_low_nxt;
      sticky_flg <= (clr_sticky ? '0 : sticky_flg) | w_sticky_set;
      any_low    <= |w_low_nxt;
      alarm_vld  <= |w_low_nxt;
      alarm_ch   <= w_alarm_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_thresh_mon.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_thresh_mon
//  Purpose  : Scoreboard bench for adc_thresh_mon (4-channel instance plus a
//             3-channel instance for out-of-range channel indices).
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_thresh_mon;

  localparam int S_NORM = 0, S_PLO = 1, S_LOW = 2, S_PCLR = 3;
  localparam int DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        smpl_vld = 1'b0;
  logic [1:0]  smpl_ch = 2'd0;
  logic [11:0] smpl = 12'd0;
  logic [47:0] thr_lo = '0;
  logic [35:0] thr_lo3 = {3{12'h800}};
  logic        clr_sticky = 1'b0;

  logic [3:0]  low_flg, sticky_flg, stale_flg;
  logic        any_low, alarm_vld;
  logic [1:0]  alarm_ch;

  logic [2:0]  low_flg3, sticky_flg3, stale_flg3;
  logic        any_low3, alarm_vld3;
  logic [1:0]  alarm_ch3;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_st[4];
  int          m_cnt[4];
  logic [3:0]  m_low, m_sticky;
  logic [1:0]  m_alarm;
  logic [11:0] sb_q[$];
  logic [11:0] exp_v, obs_v;

  adc_thresh_mon #(.NUM_CH(4)) u_dut (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_ch(smpl_ch), .smpl(smpl),
    .thr_lo(thr_lo), .clr_sticky(clr_sticky), .low_flg(low_flg),
    .sticky_flg(sticky_flg), .any_low(any_low), .alarm_ch(alarm_ch),
    .alarm_vld(alarm_vld), .stale_flg(stale_flg)
  );

  adc_thresh_mon #(.NUM_CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .smpl_vld(smpl_vld), .smpl_ch(smpl_ch), .smpl(smpl),
    .thr_lo(thr_lo3), .clr_sticky(clr_sticky), .low_flg(low_flg3),
    .sticky_flg(sticky_flg3), .any_low(any_low3), .alarm_ch(alarm_ch3),
    .alarm_vld(alarm_vld3), .stale_flg(stale_flg3)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_st[k]  = S_NORM;
      m_cnt[k] = 0;
    end
    m_low = '0; m_sticky = '0; m_alarm = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input int ch, input logic [11:0] v, input logic clr);
    logic [11:0] thr, rel;
    logic [12:0] rs;
    logic        lo, rl;
    logic [3:0]  old;
    old = m_low;
    thr = thr_lo[ch*12 +: 12];
    rs  = {1'b0, thr} + 13'h020;
    rel = (rs > 13'h0FFF) ? 12'hFFF : rs[11:0];
    lo  = (v < thr);
    rl  = (v >= rel);
    case (m_st[ch])
      S_NORM: if (lo) begin m_st[ch] = S_PLO; m_cnt[ch] = 1; end
      S_PLO: begin
        if (lo) begin
          m_cnt[ch]++;
          if (m_cnt[ch] == DEB) begin m_st[ch] = S_LOW; m_cnt[ch] = 0; end
        end else begin m_st[ch] = S_NORM; m_cnt[ch] = 0; end
      end
      S_LOW: if (rl) begin m_st[ch] = S_PCLR; m_cnt[ch] = 1; end
      default: begin
        if (rl) begin
          m_cnt[ch]++;
          if (m_cnt[ch] == DEB) begin m_st[ch] = S_NORM; m_cnt[ch] = 0; end
        end else begin m_st[ch] = S_LOW; m_cnt[ch] = 0; end
      end
    endcase
    m_low[ch] = (m_st[ch] == S_LOW) || (m_st[ch] == S_PCLR);
    m_sticky  = (clr ? 4'b0 : m_sticky) | (m_low & ~old);
    for (int k = 3; k >= 0; k--) if (m_low[k]) m_alarm = 2'(k);
  endtask

  // Drive one sample and push the expected post-edge outputs.
  task automatic send(input int ch, input logic [11:0] v, input logic clr);
    @(negedge clk);
    smpl_vld = 1'b1; smpl_ch = 2'(ch); smpl = v; clr_sticky = clr;
    model_step(ch, v, clr);
    sb_q.push_back({m_low, m_sticky, |m_low, |m_low, m_alarm});
    @(posedge clk); #1;
    smpl_vld = 1'b0; clr_sticky = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({low_flg, sticky_flg, any_low, alarm_vld, alarm_ch, stale_flg} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got low=%b sticky=%b any=%b vld=%b ch=%0d stale=%b required all 0",
               low_flg, sticky_flg, any_low, alarm_vld, alarm_ch, stale_flg);
    end
  endtask

  task automatic test_reset_mid_debounce();
    thr_lo = {12'h000, 12'h000, 12'h000, 12'h800};
    do_reset();
    for (int n = 0; n < 2; n++) begin
      send(0, 12'h7FF, 1'b0);
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL pre_reset: got %h required %h", obs_v, exp_v); end
    end
    do_reset();
    for (int n = 0; n < 3; n++) begin
      send(0, 12'h7FF, 1'b0);
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL post_reset[%0d]: got %h required %h", n, obs_v, exp_v); end
      if (n < 2) begin
        checks++;
        if (low_flg !== 4'b0000) begin errors++; $display("FAIL mid_debounce_low[%0d]: got %b required 0000", n, low_flg); end
      end
    end
    checks++;
    if (low_flg[0] !== 1'b1 || alarm_ch !== 2'd0 || sticky_flg[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_debounce_low: got low0=%b ch=%0d sticky0=%b required 1 0 1", low_flg[0], alarm_ch, sticky_flg[0]);
    end
  endtask

  task automatic test_boundary_hyst();
    logic [11:0] vals[12] = '{12'h800, 12'h800, 12'h800, 12'h7FF, 12'h7FF, 12'h7FF,
                              12'h81F, 12'h81F, 12'h81F, 12'h820, 12'h820, 12'h820};
    logic [3:0]  req_low[12] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1,
                                 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
    thr_lo = {12'h000, 12'h000, 12'h000, 12'h800};
    do_reset();
    for (int n = 0; n < 12; n++) begin
      send(0, vals[n], 1'b0);
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL boundary_sb[%0d]: got %h required %h", n, obs_v, exp_v); end
      checks++;
      if (low_flg !== req_low[n]) begin errors++; $display("FAIL boundary_low[%0d]: got %b required %b", n, low_flg, req_low[n]); end
    end
  endtask

  task automatic test_interrupt_indep();
    int          chs[11] = '{2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
    logic [11:0] vals[11] = '{12'h100, 12'h900, 12'h100, 12'h900, 12'h900, 12'h900,
                              12'h100, 12'h900, 12'h100, 12'h900, 12'h100};
    thr_lo = {12'h000, 12'h200, 12'h800, 12'h000};
    do_reset();
    for (int n = 0; n < 11; n++) begin
      send(chs[n], vals[n], 1'b0);
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL interrupt_sb[%0d]: got %h required %h", n, obs_v, exp_v); end
      if (n == 6) begin
        checks++;
        if (low_flg !== 4'b0000) begin errors++; $display("FAIL interrupted_no_flag: got %b required 0000", low_flg); end
      end
    end
    checks++;
    if (low_flg !== 4'b0100 || alarm_ch !== 2'd2) begin
      errors++;
      $display("FAIL interleave_count: got low=%b ch=%0d required 0100 2", low_flg, alarm_ch);
    end
  endtask

  task automatic test_priority_sticky();
    int          chs[18] = '{3, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 3, 3};
    logic [11:0] vals[18];
    thr_lo = {4{12'h800}};
    do_reset();
    for (int n = 0; n < 18; n++) vals[n] = (n < 9) ? 12'h000 : 12'h900;
    for (int n = 0; n < 18; n++) begin
      send(chs[n], vals[n], (n == 8));
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL priority_sb[%0d]: got %h required %h", n, obs_v, exp_v); end
      if (n == 2 || n == 5) begin
        checks++;
        if (alarm_ch !== ((n == 2) ? 2'd3 : 2'd1)) begin errors++; $display("FAIL priority_ch[%0d]: got %0d required %0d", n, alarm_ch, (n == 2) ? 3 : 1); end
      end
      if (n == 8) begin
        checks++;
        if (sticky_flg !== 4'b0001 || alarm_ch !== 2'd0) begin
          errors++; $display("FAIL sticky_clear_set: got sticky=%b ch=%0d required 0001 0", sticky_flg, alarm_ch);
        end
      end
    end
    checks++;
    if (alarm_vld !== 1'b0 || alarm_ch !== 2'd3) begin
      errors++; $display("FAIL alarm_hold: got vld=%b ch=%0d required 0 3", alarm_vld, alarm_ch);
    end
  endtask

  task automatic test_out_of_range_sat();
    thr_lo = {12'h800, 12'hFF0, 12'h000, 12'h000};
    do_reset();
    for (int n = 0; n < 3; n++) begin
      send(3, 12'h000, 1'b0);
      void'(sb_q.pop_front());
    end
    checks++;
    if (low_flg3 !== 3'b000 || sticky_flg3 !== 3'b000 || any_low3 !== 1'b0) begin
      errors++; $display("FAIL out_of_range: got low=%b sticky=%b any=%b required 000 000 0", low_flg3, sticky_flg3, any_low3);
    end
    for (int n = 0; n < 3; n++) begin
      send(2, 12'h000, 1'b0);
      void'(sb_q.pop_front());
    end
    checks++;
    if (low_flg3 !== 3'b100 || alarm_ch3 !== 2'd2) begin
      errors++; $display("FAIL in_range_3ch: got low=%b ch=%0d required 100 2", low_flg3, alarm_ch3);
    end
    // Saturated release level on channel 2 of the 4-channel instance.
    for (int n = 0; n < 9; n++) begin
      send(2, (n < 3) ? 12'h000 : ((n < 6) ? 12'hFFE : 12'hFFF), 1'b0);
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL saturate_sb[%0d]: got %h required %h", n, obs_v, exp_v); end
      if (n == 5 || n == 8) begin
        checks++;
        if (low_flg[2] !== (n == 5)) begin errors++; $display("FAIL saturate_low[%0d]: got %b required %b", n, low_flg[2], (n == 5)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    thr_lo = {12'h800, 12'h810, 12'h7F8, 12'h800};
    do_reset();
    for (int n = 0; n < 200; n++) begin
      send(int'($urandom_range(0, 3)), 12'($urandom_range(12'h7E0, 12'h840)), ($urandom_range(0, 15) == 0));
      exp_v = sb_q.pop_front(); obs_v = {low_flg, sticky_flg, any_low, alarm_vld, alarm_ch};
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL back_to_back[%0d]: got %h required %h", n, obs_v, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_debounce();
    test_boundary_hyst();
    test_interrupt_indep();
    test_priority_sticky();
    test_out_of_range_sat();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
